// File: rtl/sram_loop_sequencer.sv
// rtl/sram_loop_sequencer.sv - record/playback/clear sequencer for a 12x12 register-file SRAM
module sram_loop_sequencer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rec_start,
    input  logic             play_start,
    input  logic             clr_start,
    input  logic             stop,
    input  logic             tick,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_rw,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] play_data,
    output logic             play_valid,
    output logic [AW-1:0]    loop_len,
    output logic [AW-1:0]    step,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    state_t        state;
    logic [AW-1:0] ptr;

    // Write strobe is combinational so a recorded tick lands at the same edge it is seen.
    assign mem_rw   = !RST && !stop && ((state == RECORD && tick) || state == CLEAR);
    assign mem_din  = (state == CLEAR) ? '0 : pad_in;
    assign mem_addr = ptr;
    assign step     = ptr;
    assign busy     = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            ptr        <= '0;
            loop_len   <= '0;
            play_data  <= '0;
            play_valid <= 1'b0;
        end else begin
            play_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop) begin
                        ptr <= '0;
                    end else if (clr_start) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        loop_len <= '0;
                    end else if (rec_start) begin
                        state    <= RECORD;
                        ptr      <= '0;
                        loop_len <= '0;
                    end else if (play_start && loop_len != '0) begin
                        state <= PLAY;
                        ptr   <= '0;
                    end
                end
                RECORD: begin
                    if (stop) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else if (tick) begin
                        loop_len <= ptr + ONE;
                        if (ptr == LAST) begin
                            state <= IDLE;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + ONE;
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else if (tick) begin
                        play_data  <= mem_dout;
                        play_valid <= 1'b1;
                        ptr        <= (ptr == loop_len - ONE) ? '0 : ptr + ONE;
                    end
                end
                CLEAR: begin
                    if (stop || ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_loop_sequencer.sv
// tb/tb_sram_loop_sequencer.sv - vector table plus write/playback scoreboard for sram_loop_sequencer
module tb_sram_loop_sequencer;

    logic        CLK;
    logic        RST;
    logic        rec_start, play_start, clr_start, stop, tick;
    logic [11:0] pad_in, mem_dout, mem_din, play_data;
    logic        mem_rw, play_valid, busy;
    logic [3:0]  mem_addr, loop_len, step;

    logic [11:0] sram [0:15];

    sram_loop_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .rec_start  (rec_start),
        .play_start (play_start),
        .clr_start  (clr_start),
        .stop       (stop),
        .tick       (tick),
        .pad_in     (pad_in),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .play_data  (play_data),
        .play_valid (play_valid),
        .loop_len   (loop_len),
        .step       (step),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign mem_dout = sram[mem_addr];
    always @(posedge CLK) if (mem_rw) sram[mem_addr] <= mem_din;

    typedef struct {
        logic        rst, rec, ply, clr, stp, tk;
        logic [11:0] pad;
        logic        e_busy, e_rw;
        logic [3:0]  e_step, e_len;
        logic        e_pv;
        logic [11:0] wd;
        logic        pp;
        logic [11:0] pd;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [11:0] data;
    } wr_t;

    vec_t        vecs[$];
    wr_t         wq[$];
    logic [11:0] pq[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic av(input logic rst, rec, ply, clr, stp, tk, input logic [11:0] pad,
                      input logic bsy, rw, input logic [3:0] st, len, input logic pv,
                      input logic [11:0] wd, input logic pp, input logic [11:0] pd);
        vec_t v;
        v.rst = rst; v.rec = rec; v.ply = ply; v.clr = clr; v.stp = stp; v.tk = tk; v.pad = pad;
        v.e_busy = bsy; v.e_rw = rw; v.e_step = st; v.e_len = len; v.e_pv = pv;
        v.wd = wd; v.pp = pp; v.pd = pd;
        vecs.push_back(v);
    endtask

    // Drives one cycle's inputs and scores any write or playback word the DUT produces in it.
    task automatic drive_cycle(input logic rst, rec, ply, clr, stp, tk, input logic [11:0] pad);
        wr_t w;
        logic [11:0] p;
        @(negedge CLK);
        RST = rst; rec_start = rec; play_start = ply; clr_start = clr; stop = stp; tick = tk; pad_in = pad;
        #1;
        if (mem_rw === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write_addr", {28'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("write_addr", {28'd0, mem_addr}, {28'd0, w.addr});
                chk("write_data", {20'd0, mem_din}, {20'd0, w.data});
            end
        end
        if (play_valid === 1'b1) begin
            if (pq.size() == 0) begin
                chk("unexpected_play_valid", {20'd0, play_data}, 32'hFFFF_FFFF);
            end else begin
                p = pq.pop_front();
                chk("play_data", {20'd0, play_data}, {20'd0, p});
            end
        end
    endtask

    task automatic do_cycle(input vec_t v);
        wr_t w;
        if (v.e_rw) begin
            w.addr = v.e_step;
            w.data = v.wd;
            wq.push_back(w);
        end
        if (v.pp) pq.push_back(v.pd);
        drive_cycle(v.rst, v.rec, v.ply, v.clr, v.stp, v.tk, v.pad);
        chk("busy",       {31'd0, busy},       {31'd0, v.e_busy});
        chk("mem_rw",     {31'd0, mem_rw},     {31'd0, v.e_rw});
        chk("step",       {28'd0, step},       {28'd0, v.e_step});
        chk("mem_addr",   {28'd0, mem_addr},   {28'd0, v.e_step});
        chk("loop_len",   {28'd0, loop_len},   {28'd0, v.e_len});
        chk("play_valid", {31'd0, play_valid}, {31'd0, v.e_pv});
    endtask

    initial begin
        int  cnt;
        bit  done;
        wr_t w;

        for (int i = 0; i < 16; i++) sram[i] = 12'h000;
        RST = 1'b1; rec_start = 1'b0; play_start = 1'b0; clr_start = 1'b0;
        stop = 1'b0; tick = 1'b0; pad_in = 12'h000;

        // Reset state, empty play ignored, record three words.
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,1,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,1,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h001, 1,1,4'd0,4'd0,0, 12'h001,0,12'h000);
        av(0,0,0,0,0,0,12'h0A5, 1,0,4'd1,4'd1,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h0A5, 1,1,4'd1,4'd1,0, 12'h0A5,0,12'h000);
        av(0,0,0,0,0,1,12'hFFF, 1,1,4'd2,4'd2,0, 12'hFFF,0,12'h000);
        av(0,0,0,0,1,0,12'h000, 1,0,4'd3,4'd3,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd3,0, 12'h000,0,12'h000);
        // Playback with wrap; rec_start ignored mid-play; stop+tick suppresses the pulse.
        av(0,0,1,0,0,0,12'h000, 0,0,4'd0,4'd3,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd0,4'd3,0, 12'h000,1,12'h001);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd1,4'd3,1, 12'h000,1,12'h0A5);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd2,4'd3,1, 12'h000,1,12'hFFF);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd0,4'd3,1, 12'h000,1,12'h001);
        av(0,0,0,0,0,0,12'h000, 1,0,4'd1,4'd3,1, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd1,4'd3,0, 12'h000,1,12'h0A5);
        av(0,1,0,0,0,1,12'h000, 1,0,4'd2,4'd3,1, 12'h000,1,12'hFFF);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd0,4'd3,1, 12'h000,1,12'h001);
        av(0,0,0,0,1,1,12'h000, 1,0,4'd1,4'd3,1, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd3,0, 12'h000,0,12'h000);
        // Record collision: stop and tick together at ptr 2.
        av(0,1,0,0,0,0,12'h000, 0,0,4'd0,4'd3,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h111, 1,1,4'd0,4'd0,0, 12'h111,0,12'h000);
        av(0,0,0,0,0,1,12'h222, 1,1,4'd1,4'd1,0, 12'h222,0,12'h000);
        av(0,0,0,0,1,1,12'h333, 1,0,4'd2,4'd2,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd2,0, 12'h000,0,12'h000);
        // Full record with auto-stop, then a 13th tick that must not write.
        av(0,1,0,0,0,0,12'h000, 0,0,4'd0,4'd2,0, 12'h000,0,12'h000);
        for (int i = 0; i < 12; i++)
            av(0,0,0,0,0,1,12'(i), 1,1,4'(i),4'(i),0, 12'(i),0,12'h000);
        av(0,0,0,0,0,1,12'hABC, 0,0,4'd0,4'd12,0, 12'h000,0,12'h000);
        // Full-length playback wrapping past word 11.
        av(0,0,1,0,0,0,12'h000, 0,0,4'd0,4'd12,0, 12'h000,0,12'h000);
        for (int k = 0; k < 13; k++)
            av(0,0,0,0,0,1,12'h000, 1,0,4'(k % 12),4'd12,(k > 0), 12'h000,1,12'(k % 12));
        av(0,0,0,0,1,0,12'h000, 1,0,4'd1,4'd12,1, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd12,0, 12'h000,0,12'h000);
        // Clear: ticks and rec_start ignored, twelve zero writes, then empty play ignored.
        av(0,0,0,1,0,0,12'h000, 0,0,4'd0,4'd12,0, 12'h000,0,12'h000);
        for (int i = 0; i < 12; i++)
            av(0,(i == 5),0,0,0,i[0],12'hFFF, 1,1,4'(i),4'd0,0, 12'h000,0,12'h000);
        av(0,0,1,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        // Reset during a record tick: no write in the reset cycle.
        av(0,1,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h5A5, 1,1,4'd0,4'd0,0, 12'h5A5,0,12'h000);
        av(1,0,0,0,0,1,12'h777, 1,0,4'd1,4'd1,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        // Reset during playback.
        av(0,1,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h0C3, 1,1,4'd0,4'd0,0, 12'h0C3,0,12'h000);
        av(0,0,0,0,0,1,12'h03C, 1,1,4'd1,4'd1,0, 12'h03C,0,12'h000);
        av(0,0,0,0,1,0,12'h000, 1,0,4'd2,4'd2,0, 12'h000,0,12'h000);
        av(0,0,1,0,0,0,12'h000, 0,0,4'd0,4'd2,0, 12'h000,0,12'h000);
        av(0,0,0,0,0,1,12'h000, 1,0,4'd0,4'd2,0, 12'h000,1,12'h0C3);
        av(1,0,0,0,0,1,12'h000, 1,0,4'd1,4'd2,1, 12'h000,0,12'h000);
        av(0,0,0,0,0,0,12'h000, 0,0,4'd0,4'd0,0, 12'h000,0,12'h000);

        drive_cycle(1,0,0,0,0,0,12'h000);
        drive_cycle(1,0,0,0,0,0,12'h000);

        foreach (vecs[i]) do_cycle(vecs[i]);

        chk("play_data_after_reset", {20'd0, play_data}, 32'd0);

        // Clear run to completion, bounded by a cycle budget.
        for (int i = 0; i < 12; i++) begin
            w.addr = 4'(i);
            w.data = 12'h000;
            wq.push_back(w);
        end
        drive_cycle(0,0,0,1,0,0,12'h000);
        cnt  = 0;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            drive_cycle(0,0,0,0,0,0,12'h123);
            if (mem_rw === 1'b1) cnt++;
            if (busy === 1'b0) done = 1;
        end
        chk("clear_finished_in_budget", {31'd0, done}, 32'd1);
        chk("clear_write_cycles", cnt, 32'd12);

        // Clear aborted by stop after three writes.
        for (int i = 0; i < 3; i++) begin
            w.addr = 4'(i);
            w.data = 12'h000;
            wq.push_back(w);
        end
        sram[3] = 12'h456;
        drive_cycle(0,0,0,1,0,0,12'h000);
        for (int i = 0; i < 3; i++) drive_cycle(0,0,0,0,0,0,12'h000);
        drive_cycle(0,0,0,0,1,0,12'h000);
        chk("abort_stop_no_write", {31'd0, mem_rw}, 32'd0);
        drive_cycle(0,0,0,0,0,0,12'h000);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_loop_len", {28'd0, loop_len}, 32'd0);
        chk("abort_word3_kept", {20'd0, sram[3]}, 32'h456);

        chk("write_queue_drained", wq.size(), 32'd0);
        chk("play_queue_drained", pq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
